// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Brief    : Shared encodings for the load/store unit (funct3, FSM, errors).
// Revision : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  localparam logic [2:0] C_F3_LB  = 3'b000;
  localparam logic [2:0] C_F3_LH  = 3'b001;
  localparam logic [2:0] C_F3_LW  = 3'b010;
  localparam logic [2:0] C_F3_LBU = 3'b100;
  localparam logic [2:0] C_F3_LHU = 3'b101;

  localparam logic [2:0] C_F3_SB  = 3'b000;
  localparam logic [2:0] C_F3_SH  = 3'b001;
  localparam logic [2:0] C_F3_SW  = 3'b010;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } lsu_state_t;

  localparam logic [1:0] C_ERR_NONE     = 2'b00;
  localparam logic [1:0] C_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] C_ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] C_ERR_TIMEOUT  = 2'b11;

  // Byte enables for a store of the given size at byte offset off.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << off;
      default: store_be = 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Brief    : Shifts the read word to the addressed lane and extends it.
// Revision : 1.0 - initial release
// ============================================================================
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] w_shifted;

  assign w_shifted = mem_rdata >> {off, 3'b000};

  always_comb begin
    load_data = w_shifted;
    case (funct3)
      C_F3_LB:  load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      C_F3_LBU: load_data = {24'h000000, w_shifted[7:0]};
      C_F3_LH:  load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      C_F3_LHU: load_data = {16'h0000, w_shifted[15:0]};
      default:  load_data = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I memory stage: word-aligned req/ack bus, load extension,
//            misaligned/illegal/timeout error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_err,
  output logic [1:0]  err_cause
);

  localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  r_state;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_lsu_err;
  logic [1:0]  r_err_cause;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;

  logic        w_accept;
  logic        w_load_f3_ok;
  logic        w_store_f3_ok;
  logic        w_illegal;
  logic        w_misaligned;
  logic [31:0] w_store_wdata;
  logic [31:0] w_load_data;

  assign in_ready = reset & (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;

  assign w_load_f3_ok  = (funct3 == C_F3_LB) | (funct3 == C_F3_LH) | (funct3 == C_F3_LW) |
                         (funct3 == C_F3_LBU) | (funct3 == C_F3_LHU);
  assign w_store_f3_ok = (funct3 == C_F3_SB) | (funct3 == C_F3_SH) | (funct3 == C_F3_SW);
  assign w_illegal     = (is_load == is_store) | (is_load & ~w_load_f3_ok) |
                         (is_store & ~w_store_f3_ok);
  // Only meaningful once illegal encodings are excluded (funct3[1:0] is the size).
  assign w_misaligned  = ((funct3[1:0] == 2'b01) & addr[0]) |
                         ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));

  always_comb begin
    w_store_wdata = store_data;
    case (funct3[1:0])
      2'b00:   w_store_wdata = {4{store_data[7:0]}};
      2'b01:   w_store_wdata = {2{store_data[15:0]}};
      default: w_store_wdata = store_data;
    endcase
  end

  load_align u_load_align (
    .mem_rdata (mem_rdata),
    .off       (r_off),
    .funct3    (r_funct3),
    .load_data (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_be    <= 4'b0000;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'h0;
      r_lsu_err   <= 1'b0;
      r_err_cause <= C_ERR_NONE;
      r_is_load   <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_rd        <= 5'd0;
      r_cnt       <= 8'd0;
    end else begin
      r_wb_valid <= 1'b0;
      r_lsu_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_load <= is_load;
            r_funct3  <= funct3;
            r_off     <= addr[1:0];
            r_rd      <= rd;
            if (w_illegal) begin
              r_lsu_err   <= 1'b1;
              r_err_cause <= C_ERR_ILLEGAL;
            end else if (w_misaligned) begin
              r_lsu_err   <= 1'b1;
              r_err_cause <= C_ERR_MISALIGN;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= is_store;
              r_mem_addr <= {addr[31:2], 2'b00};
              r_mem_be   <= is_store ? store_be(funct3, addr[1:0]) : 4'b1111;
              if (is_store) r_mem_wdata <= w_store_wdata;
              r_cnt      <= 8'd0;
              r_state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
            if (r_is_load) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= w_load_data;
            end
          end else if (r_cnt == C_CNT_LAST) begin
            r_mem_req   <= 1'b0;
            r_lsu_err   <= 1'b1;
            r_err_cause <= C_ERR_TIMEOUT;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign lsu_err   = r_lsu_err;
  assign err_cause = r_err_cause;

endmodule
`default_nettype wire
